// File: rtl/bcd_multi_digit_display.sv
// Serial double-dabble binary-to-BCD converter driving NUM_DIGITS seven-segment digits.
// Converts one input bit per clock. seg changes only when a conversion completes.
module bcd_multi_digit_display #(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_W      = 14,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [BIN_W-1:0]        bin_in,
    input  logic                    load,
    input  logic                    blank_lz,
    output logic                    ready,
    output logic                    done,
    output logic                    overflow,
    output logic [7*NUM_DIGITS-1:0] seg
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int SEG_W = 7 * NUM_DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    localparam logic [63:0] MAX_VAL      = pow10(NUM_DIGITS) - 64'd1;
    localparam logic [63:0] BIN_MAX      = (64'd1 << BIN_W) - 64'd1;
    localparam bit          OVF_POSSIBLE = (BIN_MAX > MAX_VAL);

    // Glyphs are held in active-low form and inverted at the output for active-high boards.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_RESET = {SEG_W{ACTIVE_LOW}};

    function automatic logic [6:0] digit_seg(input logic [3:0] nib);
        case (nib)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               blank_q, blank_d;
    logic               ovf_q, ovf_d;
    logic               overflow_q, overflow_d;
    logic [SEG_W-1:0]   seg_q, seg_d;
    logic               done_q, done_d;

    logic [BCD_W-1:0]   bcd_adj;
    logic [SEG_W-1:0]   seg_new;
    logic               leading;
    logic [3:0]         nib;
    logic [6:0]         glyph;

    // Scan from the most significant digit; blanking stops at the first nonzero digit.
    always_comb begin
        seg_new = '0;
        leading = blank_q;
        nib     = '0;
        glyph   = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            nib = bcd_q[4*k +: 4];
            if (ovf_q) begin
                glyph = SEG_DASH;
            end else if (leading && (k != 0) && (nib == 4'd0)) begin
                glyph = SEG_BLANK;
            end else begin
                glyph   = digit_seg(nib);
                leading = 1'b0;
            end
            seg_new[7*k +: 7] = ACTIVE_LOW ? glyph : ~glyph;
        end
    end

    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        shift_d    = shift_q;
        bcd_d      = bcd_q;
        blank_d    = blank_q;
        ovf_d      = ovf_q;
        overflow_d = overflow_q;
        seg_d      = seg_q;
        done_d     = 1'b0;

        bcd_adj = bcd_q;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end

        case (state_q)
            IDLE: begin
                if (load) begin
                    shift_d = bin_in;
                    bcd_d   = '0;
                    blank_d = blank_lz;
                    ovf_d   = OVF_POSSIBLE && (64'(bin_in) > MAX_VAL);
                    count_d = CNT_W'(BIN_W);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // The carry out of the top nibble is dropped; ovf already covers that case.
                bcd_d   = {bcd_adj[BCD_W-2:0], shift_q[BIN_W-1]};
                shift_d = shift_q << 1;
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) state_d = UPDATE;
            end
            UPDATE: begin
                seg_d      = seg_new;
                overflow_d = ovf_q;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            shift_q    <= '0;
            bcd_q      <= '0;
            blank_q    <= 1'b0;
            ovf_q      <= 1'b0;
            overflow_q <= 1'b0;
            seg_q      <= SEG_RESET;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            shift_q    <= shift_d;
            bcd_q      <= bcd_d;
            blank_q    <= blank_d;
            ovf_q      <= ovf_d;
            overflow_q <= overflow_d;
            seg_q      <= seg_d;
            done_q     <= done_d;
        end
    end

    assign ready    = (state_q == IDLE);
    assign done     = done_q;
    assign overflow = overflow_q;
    assign seg      = seg_q;

endmodule
